// File: rtl/fe_pkg.sv
// Shared constants, state encoding and digit-clamp helper for the FE-to-permutation decoder.
package fe_pkg;

    localparam int unsigned N_ELEM   = 8;
    localparam int unsigned N_DIGITS = 7;
    localparam int unsigned RANK_MAX = 40319;

    localparam logic [23:0] PERM_ID_ZERO = 24'h053977;
    localparam logic [23:0] PERM_ID_MAX  = 24'hFAC688;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fe_state_e;

    typedef logic [N_ELEM-1:0][2:0] elem_list_t;

    // Entry k-1 is the legal maximum of FE digit k.
    localparam logic [2:0] DIGIT_MAX [N_DIGITS] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    function automatic logic [2:0] clamp_digit(input logic [2:0] d, input logic [2:0] dmax);
        return (d > dmax) ? dmax : d;
    endfunction

endpackage

// File: rtl/fe_pick_remove.sv
// Combinational pick-and-compact: returns list[index] and the list with that entry removed.
module fe_pick_remove
    import fe_pkg::*;
(
    input  logic [N_ELEM-1:0][2:0] list_i,
    input  logic [3:0]             len_i,
    input  logic [2:0]             index_i,
    output logic [2:0]             picked_o,
    output logic [N_ELEM-1:0][2:0] list_o
);

    always_comb begin
        picked_o = list_i[index_i];
        list_o   = '0;
        // Entries past the new length stay zero so the list never holds stale elements.
        for (int unsigned i = 0; i < N_ELEM - 1; i++) begin
            if (i + 1 < 32'(len_i)) begin
                if (i < 32'(index_i)) begin
                    list_o[3'(i)] = list_i[3'(i)];
                end else begin
                    list_o[3'(i)] = list_i[3'(i + 1)];
                end
            end
        end
    end

endmodule

// File: rtl/fe_to_perm.sv
// Decodes 7 captured factorial-expansion digits (Lehmer code) into an 8-element permutation.
// Define FE2PERM_RANK_EN to include the Horner accumulator that drives rank; otherwise rank is 0.
module fe_to_perm
    import fe_pkg::*;
#(
    parameter int unsigned RANK_W     = 16,
    parameter logic [23:0] PERM_RESET = 24'h053977
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              of1,
    input  logic [1:0]        of2,
    input  logic [1:0]        of3,
    input  logic [2:0]        of4,
    input  logic [2:0]        of5,
    input  logic [2:0]        of6,
    input  logic [2:0]        of7,
    output logic              busy,
    output logic              done,
    output logic [23:0]       perm,
    output logic [RANK_W-1:0] rank,
    output logic              digit_err
);

    fe_state_e                  state_q, state_d;
    logic [2:0]                 step_q, step_d;
    logic [N_DIGITS-1:0][2:0]   dig_q, dig_d;
    logic                       err_q, err_d;
    elem_list_t                 list_q, list_d;
    elem_list_t                 wperm_q, wperm_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [23:0]                perm_q, perm_d;
    logic                       derr_q, derr_d;

    logic [N_DIGITS-1:0][2:0]   raw;
    logic [2:0]                 idx;
    logic [3:0]                 len;
    logic [2:0]                 picked;
    elem_list_t                 list_nx;

    assign raw = {of7, of6, of5, of4, {1'b0, of3}, {1'b0, of2}, {2'b00, of1}};
    assign len = 4'd8 - {1'b0, step_q};

    // Step j consumes digit d_(7-j); the final step uses the implicit d_0 = 0.
    always_comb begin
        idx = 3'd0;
        if (step_q != 3'd7) begin
            idx = dig_q[3'd6 - step_q];
        end
    end

    fe_pick_remove u_pick (
        .list_i  (list_q),
        .len_i   (len),
        .index_i (idx),
        .picked_o(picked),
        .list_o  (list_nx)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dig_d   = dig_q;
        err_d   = err_q;
        list_d  = list_q;
        wperm_d = wperm_q;
        busy_d  = busy_q;
        done_d  = done_q;
        perm_d  = perm_q;
        derr_d  = derr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    for (int unsigned k = 0; k < N_DIGITS; k++) begin
                        dig_d[3'(k)] = clamp_digit(raw[3'(k)], DIGIT_MAX[k]);
                        if (raw[3'(k)] > DIGIT_MAX[k]) begin
                            err_d = 1'b1;
                        end
                    end
                    for (int unsigned i = 0; i < N_ELEM; i++) begin
                        list_d[3'(i)] = 3'(i);
                    end
                    step_d  = '0;
                    wperm_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                list_d                  = list_nx;
                wperm_d[3'd7 - step_q]  = picked;
                step_d                  = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    perm_d  = wperm_d;
                    derr_d  = err_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            step_q  <= '0;
            dig_q   <= '0;
            err_q   <= 1'b0;
            list_q  <= '0;
            wperm_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            perm_q  <= PERM_RESET;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dig_q   <= dig_d;
            err_q   <= err_d;
            list_q  <= list_d;
            wperm_q <= wperm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            perm_q  <= perm_d;
            derr_q  <= derr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign perm      = perm_q;
    assign digit_err = derr_q;

`ifdef FE2PERM_RANK_EN
    logic [15:0]       acc_q, acc_d;
    logic [RANK_W-1:0] rank_q, rank_d;

    // acc starts at 0, so the uniform acc*(8-j)+d step yields d7 at j=0 and is a no-op at j=7.
    always_comb begin
        acc_d  = acc_q;
        rank_d = rank_q;
        if (state_q == IDLE && start) begin
            acc_d = '0;
        end else if (state_q == RUN) begin
            acc_d = 16'(acc_q * 16'(len)) + {13'd0, idx};
            if (step_q == 3'd7) begin
                rank_d = RANK_W'(acc_d);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q  <= '0;
            rank_q <= '0;
        end else begin
            acc_q  <= acc_d;
            rank_q <= rank_d;
        end
    end

    assign rank = rank_q;
`else
    assign rank = '0;
`endif

endmodule

// File: tb/tb_fe_to_perm.sv
// Self-checking bench for fe_to_perm: scoreboard of independently decoded Lehmer codes.
module tb_fe_to_perm;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        of1;
    logic [1:0]  of2, of3;
    logic [2:0]  of4, of5, of6, of7;
    logic        busy, done, digit_err;
    logic [23:0] perm;
    logic [15:0] rank;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] perm;
        logic [15:0] rank;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];

    fe_to_perm #(.RANK_W(16), .PERM_RESET(24'h053977)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .of1      (of1),
        .of2      (of2),
        .of3      (of3),
        .of4      (of4),
        .of5      (of5),
        .of6      (of6),
        .of7      (of7),
        .busy     (busy),
        .done     (done),
        .perm     (perm),
        .rank     (rank),
        .digit_err(digit_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // digs[k-1] holds digit k; truncated to each port's width.
    task automatic drive_digits(input logic [6:0][2:0] digs);
        of1 = digs[0][0];
        of2 = digs[1][1:0];
        of3 = digs[2][1:0];
        of4 = digs[3];
        of5 = digs[4];
        of6 = digs[5];
        of7 = digs[6];
    endtask

    function automatic exp_t compute_exp(input string name);
        exp_t e;
        int d[8];
        int lst[8];
        int n, idx, f, r;
        d[0] = 0;
        d[1] = int'(of1);
        d[2] = int'(of2);
        d[3] = int'(of3);
        d[4] = int'(of4);
        d[5] = int'(of5);
        d[6] = int'(of6);
        d[7] = int'(of7);
        e.err = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (d[k] > k) begin
                d[k] = k;
                e.err = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) lst[i] = i;
        n = 8;
        e.perm = '0;
        for (int j = 0; j < 8; j++) begin
            idx = d[7-j];
            e.perm[3*(7-j) +: 3] = 3'(lst[idx]);
            for (int m = idx; m < n - 1; m++) lst[m] = lst[m+1];
            n--;
        end
        r = 0;
        f = 1;
        for (int k = 1; k <= 7; k++) begin
            f = f * k;
            r = r + d[k] * f;
        end
`ifdef FE2PERM_RANK_EN
        e.rank = 16'(r);
`else
        e.rank = '0;
`endif
        e.name = name;
        return e;
    endfunction

    task automatic run_conv(input logic [6:0][2:0] digs, input string name);
        exp_t        e;
        logic [23:0] prev;
        int          cycles;
        @(negedge CLK);
        drive_digits(digs);
        sb.push_back(compute_exp(name));
        prev  = perm;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge CLK);
            cycles++;
            if (cycles == 4) begin
                checks++;
                if (perm !== prev) begin
                    errors++;
                    $display("FAIL %s perm_held: got %h expected %h", name, perm, prev);
                end
            end
        end
        checks++;
        if (cycles != 8) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected 8", name, cycles);
        end
        if (done !== 1'b1) begin
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            checks++;
            if (perm !== e.perm) begin
                errors++;
                $display("FAIL %s perm: got %h expected %h", e.name, perm, e.perm);
            end
            checks++;
            if (rank !== e.rank) begin
                errors++;
                $display("FAIL %s rank: got %0d expected %0d", e.name, rank, e.rank);
            end
            checks++;
            if (digit_err !== e.err) begin
                errors++;
                $display("FAIL %s digit_err: got %b expected %b", e.name, digit_err, e.err);
            end
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_busy_fall: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        start = 1'b0;
        drive_digits('0);
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        checks++;
        if (perm !== 24'h053977) begin errors++; $display("FAIL reset perm: got %h expected 053977", perm); end
        checks++;
        if (rank !== 16'd0) begin errors++; $display("FAIL reset rank: got %0d expected 0", rank); end
        checks++;
        if (digit_err !== 1'b0) begin errors++; $display("FAIL reset digit_err: got %b expected 0", digit_err); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_patterns();
        run_conv({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, "zeros");
        run_conv({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, "max");
        run_conv({3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, "of7_one");
        run_conv({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, "of1_one");
    endtask

    task automatic test_clamp();
        run_conv({3'd0, 3'd0, 3'd0, 3'd6, 3'd0, 3'd3, 3'd0}, "clamp");
        run_conv({3'd2, 3'd1, 3'd3, 3'd0, 3'd2, 3'd1, 3'd1}, "clean_after_clamp");
    endtask

    task automatic test_random();
        logic [6:0][2:0] digs;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 7; k++) digs[k] = 3'($urandom_range(k + 1, 0));
            run_conv(digs, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0][2:0] da;
        logic [6:0][2:0] db;
        exp_t e;
        int   ndone;
        int   cycles;
        da    = {3'd3, 3'd0, 3'd5, 3'd1, 3'd2, 3'd2, 3'd1};
        db    = {3'd0, 3'd6, 3'd0, 3'd4, 3'd0, 3'd1, 3'd0};
        ndone = 0;
        @(negedge CLK);
        drive_digits(da);
        sb.push_back(compute_exp("b2b_first"));
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b unexpected_done: got done at step %0d expected none", k);
                end else begin
                    e = sb.pop_front();
                    if (perm !== e.perm || rank !== e.rank) begin
                        errors++;
                        $display("FAIL %s result: got %h/%0d expected %h/%0d", e.name, perm, rank, e.perm, e.rank);
                    end
                end
            end
            if (k == 3) drive_digits(db);
            start = (k == 3 || k == 9 || k == 10);
            if (k == 10) sb.push_back(compute_exp("b2b_second"));
        end
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL b2b done_count: got %0d expected 1", ndone);
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge CLK);
            cycles++;
        end
        checks++;
        if (cycles != 8) begin
            errors++;
            $display("FAIL b2b second_latency: got %0d cycles expected 8", cycles);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (done === 1'b1) begin
                checks++;
                if (perm !== e.perm || rank !== e.rank) begin
                    errors++;
                    $display("FAIL %s result: got %h/%0d expected %h/%0d", e.name, perm, rank, e.perm, e.rank);
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_mid_reset();
        int ndone;
        run_conv({3'd0, 3'd0, 3'd0, 3'd6, 3'd0, 3'd3, 3'd0}, "clamp_before_reset");
        @(negedge CLK);
        drive_digits({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy_done: got %b %b expected 0 0", busy, done);
        end
        checks++;
        if (perm !== 24'h053977) begin
            errors++;
            $display("FAIL mid_reset perm: got %h expected 053977", perm);
        end
        checks++;
        if (rank !== 16'd0 || digit_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset rank_err: got %0d %b expected 0 0", rank, digit_err);
        end
        @(negedge CLK);
        RST   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge CLK);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL mid_reset no_done: got %0d active cycles expected 0", ndone);
        end
        run_conv({3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, "after_reset");
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_clamp();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
